// File: rtl/lc4_div_iter.sv
// Iterative unsigned divider for the LC4 ALU: restoring long division, one quotient bit per
// cycle, with valid/ready handshakes on both the operand and result sides.
module lc4_div_iter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_quotient,
  output logic [W-1:0] out_remainder
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LastCount = CW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] count_q, count_d;

  logic [W-1:0]  shifted;
  logic [W:0]    diff;
  logic          accept;
  logic          divisor_zero;

  // Trial subtraction in adder form; diff[W] is the carry-out, set when no borrow occurred.
  assign shifted      = {rem_q[W-2:0], q_q[W-1]};
  assign diff         = {1'b0, shifted} + {1'b0, ~div_q} + {{W{1'b0}}, 1'b1};
  assign divisor_zero = (in_divisor == '0);

  assign in_ready      = (state_q == StIdle) && rst_n;
  assign out_valid     = (state_q == StDone);
  assign accept        = in_valid && in_ready;
  assign out_quotient  = q_q;
  assign out_remainder = rem_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    div_d   = div_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (divisor_zero) begin
            // Divide-by-zero yields zero quotient and zero remainder.
            q_d     = '0;
            rem_d   = '0;
            state_d = StDone;
          end else begin
            q_d     = in_dividend;
            div_d   = in_divisor;
            rem_d   = '0;
            count_d = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d   = diff[W] ? diff[W-1:0] : shifted;
        q_d     = {q_q[W-2:0], diff[W]};
        count_d = count_q + 1'b1;
        if (count_q == LastCount) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      count_q <= count_d;
    end
  end

endmodule
